// File: rtl/ysyx_22040386_defines.sv
// Shared definitions for the ysyx_22040386 pipeline.
//  NOP_INST : canonical bubble instruction (addi x0,x0,0) loaded by flushed stages
//  REG_ZERO : architectural x0, never a real data dependency
//  pipe_state_e : pipeline-controller sequencing states
package ysyx_22040386_defines;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/ysyx_22040386_sat_cnt.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//  i_SAT_CNT_clk   clock
//  i_SAT_CNT_rst_n asynchronous reset, active low
//  i_SAT_CNT_inc   count this cycle
//  i_SAT_CNT_clr   synchronous clear (wins over inc)
//  o_SAT_CNT_cnt   current count, sticks at all-ones
module ysyx_22040386_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_SAT_CNT_clk,
  input  logic             i_SAT_CNT_rst_n,
  input  logic             i_SAT_CNT_inc,
  input  logic             i_SAT_CNT_clr,
  output logic [CNT_W-1:0] o_SAT_CNT_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_SAT_CNT_clk or negedge i_SAT_CNT_rst_n) begin
    if (!i_SAT_CNT_rst_n) begin
      r_cnt <= '0;
    end else if (i_SAT_CNT_clr) begin
      r_cnt <= '0;
    end else if (i_SAT_CNT_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_SAT_CNT_cnt = r_cnt;

endmodule

// File: rtl/ysyx_22040386_pipe_ctrl.sv
// Hazard / sequencing controller for the 5-stage RV64 pipeline.
// Ports:
//  i_PIPE_CTRL_clk, i_PIPE_CTRL_rst_n         clock, async active-low reset
//  i_PIPE_CTRL_id_rs1/rs2, *_used             ID-stage source operands
//  i_PIPE_CTRL_ex_is_load, ex_rd, ex_jump     EX-stage load / destination / taken jump
//  i_PIPE_CTRL_lsu_req, lsu_ready             MEM-stage data access handshake
//  o_PIPE_CTRL_jump_flag                      flush IF/ID + ID/EX, redirect PC
//  o_PIPE_CTRL_load_use_flag                  hold PC + IF/ID, bubble ID/EX
//  o_PIPE_CTRL_mem_stall                      hold PC..EX/MEM, bubble MEM/WB
//  o_PIPE_CTRL_bus_err                        sticky data-bus timeout
//  o_PIPE_CTRL_stall_cnt, flush_cnt           saturating performance counters
module ysyx_22040386_pipe_ctrl
  import ysyx_22040386_defines::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             i_PIPE_CTRL_clk,
  input  logic             i_PIPE_CTRL_rst_n,
  input  logic [4:0]       i_PIPE_CTRL_id_rs1,
  input  logic [4:0]       i_PIPE_CTRL_id_rs2,
  input  logic             i_PIPE_CTRL_id_rs1_used,
  input  logic             i_PIPE_CTRL_id_rs2_used,
  input  logic             i_PIPE_CTRL_ex_is_load,
  input  logic [4:0]       i_PIPE_CTRL_ex_rd,
  input  logic             i_PIPE_CTRL_ex_jump,
  input  logic             i_PIPE_CTRL_lsu_req,
  input  logic             i_PIPE_CTRL_lsu_ready,
  output logic             o_PIPE_CTRL_jump_flag,
  output logic             o_PIPE_CTRL_load_use_flag,
  output logic             o_PIPE_CTRL_mem_stall,
  output logic             o_PIPE_CTRL_bus_err,
  output logic [CNT_W-1:0] o_PIPE_CTRL_stall_cnt,
  output logic [CNT_W-1:0] o_PIPE_CTRL_flush_cnt
);

  // Wide enough to hold MEM_TIMEOUT-1, the last count before the error trip.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  pipe_state_e       r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_bus_err;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_hz_lu;
  logic w_hz_mem;
  logic w_jump_flag;
  logic w_load_use_flag;
  logic w_mem_stall;

  assign w_rs1_hit = i_PIPE_CTRL_id_rs1_used & (i_PIPE_CTRL_id_rs1 == i_PIPE_CTRL_ex_rd);
  assign w_rs2_hit = i_PIPE_CTRL_id_rs2_used & (i_PIPE_CTRL_id_rs2 == i_PIPE_CTRL_ex_rd);
  assign w_hz_lu   = i_PIPE_CTRL_ex_is_load & (i_PIPE_CTRL_ex_rd != REG_ZERO) & (w_rs1_hit | w_rs2_hit);
  assign w_hz_mem  = i_PIPE_CTRL_lsu_req & ~i_PIPE_CTRL_lsu_ready;

  // Memory stall outranks everything: EX is frozen during it, so a pending
  // jump simply waits and fires on the release cycle. A jump flushes the
  // load-use victim anyway, so it outranks the load-use bubble.
  always_comb begin
    w_jump_flag     = 1'b0;
    w_load_use_flag = 1'b0;
    w_mem_stall     = 1'b0;
    if (i_PIPE_CTRL_rst_n) begin
      if (r_state == ST_ERR) begin
        w_mem_stall = 1'b1;
      end else begin
        w_mem_stall     = w_hz_mem;
        w_jump_flag     = i_PIPE_CTRL_ex_jump & ~w_hz_mem;
        w_load_use_flag = w_hz_lu & ~w_hz_mem & ~i_PIPE_CTRL_ex_jump;
      end
    end
  end

  always_ff @(posedge i_PIPE_CTRL_clk or negedge i_PIPE_CTRL_rst_n) begin
    if (!i_PIPE_CTRL_rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hz_mem) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (i_PIPE_CTRL_lsu_ready || !i_PIPE_CTRL_lsu_req) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            r_state   <= ST_ERR;
            r_bus_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_ERR: begin
          // Only reset leaves the error state.
          r_bus_err <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  ysyx_22040386_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_SAT_CNT_clk   (i_PIPE_CTRL_clk),
    .i_SAT_CNT_rst_n (i_PIPE_CTRL_rst_n),
    .i_SAT_CNT_inc   (w_load_use_flag | w_mem_stall),
    .i_SAT_CNT_clr   (1'b0),
    .o_SAT_CNT_cnt   (o_PIPE_CTRL_stall_cnt)
  );

  ysyx_22040386_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_SAT_CNT_clk   (i_PIPE_CTRL_clk),
    .i_SAT_CNT_rst_n (i_PIPE_CTRL_rst_n),
    .i_SAT_CNT_inc   (w_jump_flag),
    .i_SAT_CNT_clr   (1'b0),
    .o_SAT_CNT_cnt   (o_PIPE_CTRL_flush_cnt)
  );

  assign o_PIPE_CTRL_jump_flag     = w_jump_flag;
  assign o_PIPE_CTRL_load_use_flag = w_load_use_flag;
  assign o_PIPE_CTRL_mem_stall     = w_mem_stall;
  assign o_PIPE_CTRL_bus_err       = r_bus_err;

endmodule

// File: tb/tb_ysyx_22040386_pipe_ctrl.sv
// Directed scoreboard bench for ysyx_22040386_pipe_ctrl (MEM_TIMEOUT=4, CNT_W=8).
module tb_ysyx_22040386_pipe_ctrl;

  localparam logic [2:0] N = 3'b000;  // {jump, load_use, mem_stall}
  localparam logic [2:0] J = 3'b100;
  localparam logic [2:0] L = 3'b010;
  localparam logic [2:0] M = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, ex_rd = '0;
  logic       rs1_used = 0, rs2_used = 0, ex_is_load = 0, ex_jump = 0;
  logic       lsu_req = 0, lsu_ready = 0;
  logic       jump_flag, load_use_flag, mem_stall, bus_err;
  logic [7:0] stall_cnt, flush_cnt;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string      nm;
    logic [2:0] flg;
    logic       be;
    logic [7:0] sc;
    logic [7:0] fc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  ysyx_22040386_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .i_PIPE_CTRL_clk           (clk),
    .i_PIPE_CTRL_rst_n         (rst_n),
    .i_PIPE_CTRL_id_rs1        (rs1),
    .i_PIPE_CTRL_id_rs2        (rs2),
    .i_PIPE_CTRL_id_rs1_used   (rs1_used),
    .i_PIPE_CTRL_id_rs2_used   (rs2_used),
    .i_PIPE_CTRL_ex_is_load    (ex_is_load),
    .i_PIPE_CTRL_ex_rd         (ex_rd),
    .i_PIPE_CTRL_ex_jump       (ex_jump),
    .i_PIPE_CTRL_lsu_req       (lsu_req),
    .i_PIPE_CTRL_lsu_ready     (lsu_ready),
    .o_PIPE_CTRL_jump_flag     (jump_flag),
    .o_PIPE_CTRL_load_use_flag (load_use_flag),
    .o_PIPE_CTRL_mem_stall     (mem_stall),
    .o_PIPE_CTRL_bus_err       (bus_err),
    .o_PIPE_CTRL_stall_cnt     (stall_cnt),
    .o_PIPE_CTRL_flush_cnt     (flush_cnt)
  );

  task automatic check(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.nm, "flags", {5'd0, jump_flag, load_use_flag, mem_stall}, {5'd0, e.flg});
      check(e.nm, "bus_err", {7'd0, bus_err}, {7'd0, e.be});
      check(e.nm, "stall_cnt", stall_cnt, e.sc);
      check(e.nm, "flush_cnt", flush_cnt, e.fc);
      $display("cycle %s: flags=%b bus_err=%b stall_cnt=%0d flush_cnt=%0d", e.nm,
               {jump_flag, load_use_flag, mem_stall}, bus_err, stall_cnt, flush_cnt);
    end
  end

  task automatic step(input string nm, input logic rst,
                      input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                      input logic ld, input logic [4:0] rd, input logic jmp, input logic req,
                      input logic rdy, input logic [2:0] flg, input logic be, input int sc, input int fc);
    exp_t e;
    rst_n = rst; rs1 = a1; rs2 = a2; rs1_used = u1; rs2_used = u2;
    ex_is_load = ld; ex_rd = rd; ex_jump = jmp; lsu_req = req; lsu_ready = rdy;
    e.nm = nm; e.flg = flg; e.be = be; e.sc = 8'(sc); e.fc = 8'(fc);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    //   name        rst rs1 rs2 u1 u2 ld rd jmp req rdy  flg be sc fc
    step("rst",       0,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 0, 0);
    step("rst_haz",   0,  5,  0, 1, 0, 1, 5, 1,  1,  0,  N, 0, 0, 0);
    step("idle0",     1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 0, 0);
    step("lu_rs1",    1,  5,  0, 1, 0, 1, 5, 0,  0,  0,  L, 0, 0, 0);
    step("lu_after",  1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 1, 0);
    step("lu_rd0",    1,  0,  0, 1, 0, 1, 0, 0,  0,  0,  N, 0, 1, 0);
    step("lu_nouse",  1,  5,  0, 0, 0, 1, 5, 0,  0,  0,  N, 0, 1, 0);
    step("lu_noload", 1,  5,  0, 1, 0, 0, 5, 0,  0,  0,  N, 0, 1, 0);
    step("lu_rs2",    1,  0,  7, 0, 1, 1, 7, 0,  0,  0,  L, 0, 1, 0);
    step("idle1",     1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 2, 0);
    step("jmp_lu",    1,  5,  0, 1, 0, 1, 5, 1,  0,  0,  J, 0, 2, 0);
    step("idle2",     1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 2, 1);
    step("mw1",       1,  0,  0, 0, 0, 0, 0, 1,  1,  0,  M, 0, 2, 1);
    step("mw2",       1,  0,  0, 0, 0, 0, 0, 1,  1,  0,  M, 0, 3, 1);
    step("mw3",       1,  0,  0, 0, 0, 0, 0, 1,  1,  0,  M, 0, 4, 1);
    step("mw_rel",    1,  0,  0, 0, 0, 0, 0, 1,  1,  1,  J, 0, 5, 1);
    step("idle3",     1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 5, 2);
    step("wd_stall",  1,  5,  0, 1, 0, 1, 5, 0,  1,  0,  M, 0, 5, 2);
    step("wd_drop",   1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 6, 2);
    step("idle4",     1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 6, 2);
    step("to1",       1,  0,  0, 0, 0, 0, 0, 0,  1,  0,  M, 0, 6, 2);
    step("to2",       1,  0,  0, 0, 0, 0, 0, 0,  1,  0,  M, 0, 7, 2);
    step("to3",       1,  0,  0, 0, 0, 0, 0, 0,  1,  0,  M, 0, 8, 2);
    step("to4",       1,  0,  0, 0, 0, 0, 0, 0,  1,  0,  M, 0, 9, 2);
    step("err",       1,  0,  0, 0, 0, 0, 0, 0,  1,  0,  M, 1, 10, 2);
    step("err_rdy",   1,  5,  0, 1, 0, 1, 5, 1,  1,  1,  M, 1, 11, 2);
    step("err_idle",  1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  M, 1, 12, 2);
    for (int i = 0; i < 260; i++) begin
      step("sat", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, M, 1, (13 + i > 255) ? 255 : 13 + i, 2);
    end
    step("rst2",      0,  0,  0, 0, 0, 0, 0, 0,  1,  0,  N, 0, 0, 0);
    step("rst2_rel",  1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 0, 0);
    step("post_lu",   1,  5,  0, 1, 0, 1, 5, 0,  0,  0,  L, 0, 0, 0);
    step("post_idle", 1,  0,  0, 0, 0, 0, 0, 0,  0,  0,  N, 0, 1, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
